// File: rtl/if_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
//   instr_req    : fetch stage requests a word at instr_addr
//   instr_addr   : word-aligned request address
//   instr_gnt    : memory accepts the request this cycle
//   instr_rvalid : in-order response valid, at least one cycle after grant
//   instr_rdata  : response instruction word
// master = fetch stage, slave = memory.
interface if_stage_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;

  modport master (output instr_req, instr_addr, input instr_gnt, instr_rvalid, instr_rdata);
  modport slave  (input instr_req, instr_addr, output instr_gnt, instr_rvalid, instr_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: issues sequential fetches, tracks outstanding
// requests, discards wrong-path responses after a redirect, buffers returned
// words in a small FIFO and feeds the IF/ID register.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   imem (master)            instruction memory req/gnt/rvalid bus
//   stall_if_i, flush_id_i   hazard controller hold / invalidate of ID outputs
//   branch_decision_ex_i,
//   branch_target_ex_i       taken branch from EX (wins over jump)
//   jump_id_i,
//   jump_target_id_i         JAL/JALR redirect from ID
//   instr_id_o, pc_id_o,
//   valid_id_o               IF/ID register
//
// Build option: define IF_PREFETCH_EN for a 2-deep FIFO with 2 outstanding
// requests (1 instr/cycle); otherwise 1-deep FIFO, 1 outstanding.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  if_stage_if.master  imem,
  input  logic        stall_if_i,
  input  logic        flush_id_i,
  input  logic        branch_decision_ex_i,
  input  logic [31:0] branch_target_ex_i,
  input  logic        jump_id_i,
  input  logic [31:0] jump_target_id_i,
  output logic [31:0] instr_id_o,
  output logic [31:0] pc_id_o,
  output logic        valid_id_o
);

`ifdef IF_PREFETCH_EN
  localparam int DEPTH   = 2;
  localparam int MAX_OUT = 2;
`else
  localparam int DEPTH   = 1;
  localparam int MAX_OUT = 1;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_ent_t;

  logic [31:2] r_fetch_pc;
  logic [1:0]  r_out;
  logic [1:0]  r_kill;
  logic [1:0]  r_cnt;
  fetch_ent_t  r_q [DEPTH];

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_unused;
  logic [31:0] w_fetch_addr;
  logic        w_fire;
  logic        w_rv;
  logic        w_resp_ok;
  logic        w_id_en;
  logic        w_pop;
  logic        w_bypass;
  logic        w_push;
  logic [1:0]  w_free;
  logic [1:0]  w_live;
  logic [31:0] w_resp_pc;
  fetch_ent_t  w_resp;
  fetch_ent_t  w_q_n [DEPTH];
  logic [1:0]  w_cnt_n;
  logic [1:0]  w_out_n;
  logic [1:0]  w_kill_n;

  assign w_redirect = branch_decision_ex_i | jump_id_i;
  assign w_target   = branch_decision_ex_i ? branch_target_ex_i : jump_target_id_i;
  assign w_unused   = ^w_target[1:0];

  assign w_fetch_addr = {r_fetch_pc, 2'b00};

  // Responses only count while something is outstanding; strays are ignored.
  assign w_rv      = imem.instr_rvalid && (r_out != 2'd0);
  assign w_resp_ok = w_rv && (r_kill == 2'd0) && !w_redirect;

  // A redirect makes the FIFO contents wrong-path, so nothing is popped then.
  assign w_id_en  = !flush_id_i && !stall_if_i;
  assign w_pop    = w_id_en && (r_cnt != 2'd0) && !w_redirect;
  // Empty FIFO: a fresh response goes straight into the ID register.
  assign w_bypass = w_id_en && (r_cnt == 2'd0) && w_resp_ok;
  assign w_push   = w_resp_ok && !w_bypass;

  // Free slots include the one vacated by this cycle's pop; every outstanding
  // request owns a slot, so a push can never overflow.
  assign w_free = 2'(DEPTH) - r_cnt + {1'b0, w_pop};

  assign imem.instr_req  = !rst_i && (r_out < 2'(MAX_OUT)) && (w_free > r_out);
  assign imem.instr_addr = w_fetch_addr;
  assign w_fire          = imem.instr_req && imem.instr_gnt;

  // Live (non-killed) requests were issued back-to-back from the current
  // path, so the next response belongs to fetch_pc - 4*live.
  assign w_live    = r_out - r_kill;
  assign w_resp_pc = w_fetch_addr - {28'd0, w_live, 2'b00};
  assign w_resp    = {w_resp_pc, imem.instr_rdata};

  assign w_out_n  = r_out + {1'b0, w_fire} - {1'b0, w_rv};
  // Everything still in flight after a redirect, including a request granted
  // in the redirect cycle, is wrong-path.
  assign w_kill_n = w_redirect ? w_out_n :
                    (w_rv && (r_kill != 2'd0)) ? r_kill - 2'd1 : r_kill;

  always_comb begin
    w_q_n   = r_q;
    w_cnt_n = r_cnt;
    if (w_redirect) begin
      w_cnt_n = 2'd0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) w_q_n[i] = r_q[i + 1];
        w_cnt_n = r_cnt - 2'd1;
      end
      if (w_push) begin
        for (int i = 0; i < DEPTH; i++)
          if (2'(i) == w_cnt_n) w_q_n[i] = w_resp;
        w_cnt_n = w_cnt_n + 2'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_fetch_pc <= BOOT_ADDR[31:2];
      r_out      <= 2'd0;
      r_kill     <= 2'd0;
      r_cnt      <= 2'd0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      if (w_redirect)  r_fetch_pc <= w_target[31:2];
      else if (w_fire) r_fetch_pc <= r_fetch_pc + 30'd1;
      r_out  <= w_out_n;
      r_kill <= w_kill_n;
      r_cnt  <= w_cnt_n;
      r_q    <= w_q_n;
    end
  end

  // IF/ID register: flush > stall > pop/bypass > bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_id_o <= 1'b0;
      instr_id_o <= NOP;
      pc_id_o    <= 32'd0;
    end else if (flush_id_i) begin
      valid_id_o <= 1'b0;
      instr_id_o <= NOP;
    end else if (!stall_if_i) begin
      if (w_pop) begin
        valid_id_o <= 1'b1;
        instr_id_o <= r_q[0].instr;
        pc_id_o    <= r_q[0].pc;
      end else if (w_bypass) begin
        valid_id_o <= 1'b1;
        instr_id_o <= w_resp.instr;
        pc_id_o    <= w_resp.pc;
      end else begin
        valid_id_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter BOOT_ADDR, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  in  1  asynchronous, active-high reset.
REQ-004 instr_req_o  out  1  instruction memory request.
REQ-005 instr_addr_o  out  32  request address, word aligned.
REQ-006 instr_gnt_i  in  1  request accepted this cycle.
REQ-007 instr_rvalid_i  in  1  response valid, in order, at least 1 cycle after grant.
REQ-008 instr_rdata_i  in  32  response instruction word.
REQ-009 stall_if_i  in  1  hazard controller stall: hold ID outputs.
REQ-010 flush_id_i  in  1  hazard controller flush: invalidate ID outputs.
REQ-011 branch_decision_ex_i / branch_target_ex_i  in  1 / 32  taken branch from EX and its target.
REQ-012 jump_id_i / jump_target_id_i  in  1 / 32  JAL/JALR in ID and its target.
REQ-013 instr_id_o / pc_id_o / valid_id_o  out  32 / 32 / 1  IF/ID register contents.

Function
REQ-014 fetch_pc register SHALL drive instr_addr_o with bits [1:0] forced to 0.
REQ-015 instr_req_o SHALL be high iff outstanding < MAX_OUT and FIFO free slots > outstanding.
REQ-016 On req&&gnt: fetch_pc += 4 (32-bit wrap 0xFFFF_FFFC -> 0), outstanding += 1.
REQ-017 With req high and gnt low, instr_addr_o SHALL stay stable unless a redirect occurs.
REQ-018 rvalid with kill_cnt == 0 SHALL push rdata and its PC into the FIFO; outstanding -= 1.
REQ-019 rvalid with kill_cnt > 0 SHALL drop the data; kill_cnt -= 1 and outstanding -= 1.
REQ-020 rvalid with outstanding == 0 SHALL be ignored.
REQ-021 Simultaneous grant and rvalid SHALL leave outstanding unchanged.
REQ-022 Redirect = branch_decision_ex_i OR jump_id_i; the branch target SHALL have priority.
REQ-023 On redirect: fetch_pc <= target; FIFO cleared; kill_cnt <= outstanding not yet returned, including a request granted in the same cycle; a response arriving that cycle is dropped.
REQ-024 An ungranted request SHALL move to the target address the cycle after redirect without a kill.
REQ-025 ID register update priority: flush_id_i > stall_if_i > pop.
REQ-026 flush_id_i SHALL clear valid_id_o next cycle; instr_id_o SHALL become 32'h0000_0013 (NOP).
REQ-027 stall_if_i without flush SHALL hold all three ID outputs; fetching SHALL continue while FIFO space remains.
REQ-028 Otherwise: FIFO non-empty pops into instr_id_o/pc_id_o with valid_id_o=1; empty gives valid_id_o=0.
REQ-029 Latency with zero-wait memory: redirect in cycle N -> target request N+1 -> valid_id_o=1 with target PC at N+3.
REQ-030 A FIFO push and pop in the same cycle SHALL be allowed when full; the popped entry is the oldest.

Reset
REQ-031 While rst_i is high: fetch_pc=BOOT_ADDR, instr_req_o=0, FIFO empty, outstanding=0, kill_cnt=0.
REQ-032 Reset values: valid_id_o=0, instr_id_o=32'h0000_0013, pc_id_o=0.
REQ-033 The first request SHALL issue in the first clock edge cycle after rst_i deasserts.
REQ-034 Reset mid-transaction SHALL discard all in-flight state; later stray rvalid is covered by REQ-020.

Configuration
REQ-035 Macro IF_PREFETCH_EN defined: FIFO depth 2, MAX_OUT=2, sustained 1 instruction/cycle with zero-wait memory.
REQ-036 Macro IF_PREFETCH_EN undefined: FIFO depth 1, MAX_OUT=1, at most 1 instruction every 2 cycles; all other requirements unchanged.

Verification
REQ-037 Reset release, BOOT_ADDR=0x80, zero-wait memory -> requests 0x80,0x84,0x88; valid_id_o with pc_id_o 0x80 then consecutive (prefetch: every cycle).
REQ-038 Branch at 0x200 while 2 outstanding -> both stale responses dropped; next valid pc_id_o=0x200; kill_cnt returns to 0.
REQ-039 branch_decision_ex_i (0x300) and jump_id_i (0x400) in the same cycle -> next request address 0x300.
REQ-040 stall_if_i held 3 cycles with FIFO filling -> ID outputs constant; req drops when FIFO space is reserved; no instruction lost or duplicated.
REQ-041 gnt withheld 4 cycles -> instr_addr_o stable at 0x84; flush_id_i together with stall_if_i -> valid_id_o=0 next cycle.
REQ-042 rst_i pulsed with 1 outstanding, then rvalid asserted -> ignored; fetch restarts at BOOT_ADDR.
